// File: rtl/bcd_7seg_scanner.sv
// bcd_7seg_scanner
// Time-multiplexed 7-segment driver fed by packed BCD from a binary-to-BCD
// converter. A one-entry pending buffer takes new values over a valid/ready
// handshake. The visible digit register is refreshed only at frame
// boundaries, so the display never tears. Each digit slot starts with a
// one-cycle blanking guard.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   bcd_valid   packed_bcd carries a new value
//   bcd_ready   pending buffer empty, a value can be accepted
//   packed_bcd  4*DIGITS bits of BCD, [3:0] = least significant digit
//   seg_n       segments {g,f,e,d,c,b,a}, active low
//   an_n        one-hot digit anodes, active low, an_n[k] = digit k
//   frame_done  high during the last cycle of each frame
module bcd_7seg_scanner #(
  parameter int DIGITS          = 2,
  parameter int REFRESH_DIV     = 1000,
  parameter int BLANK_LEAD_ZERO = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bcd_valid,
  output logic                  bcd_ready,
  input  logic [4*DIGITS-1:0]   packed_bcd,
  output logic [6:0]            seg_n,
  output logic [DIGITS-1:0]     an_n,
  output logic                  frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

  // Slot phase, derived from cnt.
  localparam logic [0:0] SLOT_BLANK = 1'b0;
  localparam logic [0:0] SLOT_DRIVE = 1'b1;

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] disp_reg;
  logic [4*DIGITS-1:0] pend_reg;
  logic                pend_flag;

  logic [0:0] slot;
  logic       cnt_last;
  logic [3:0] nib;
  logic       higher_zero;
  logic [3:0] sel_digit;
  logic       sel_blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h3F;
    endcase
  endfunction

  assign cnt_last   = (cnt == CNT_MAX);
  assign frame_done = cnt_last && (idx == IDX_MAX);
  assign bcd_ready  = !pend_flag;
  assign slot       = (cnt == '0) ? SLOT_BLANK : SLOT_DRIVE;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      disp_reg  <= '0;
      pend_reg  <= '0;
      pend_flag <= 1'b0;
    end else begin
      if (cnt_last) begin
        cnt <= '0;
        idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // Commit needs pend_flag set and capture needs it clear, so the two
      // branches are exclusive; a capture on a commit edge waits a frame.
      if (frame_done && pend_flag) begin
        disp_reg  <= pend_reg;
        pend_flag <= 1'b0;
      end else if (bcd_valid && !pend_flag) begin
        pend_reg  <= packed_bcd;
        pend_flag <= 1'b1;
      end
    end
  end

  // Walk digits from the most significant down, tracking whether this digit
  // and everything above it is zero; pick out the digit under the scan.
  always_comb begin
    nib         = '0;
    higher_zero = 1'b1;
    sel_digit   = '0;
    sel_blank   = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      nib         = disp_reg[(DIGITS-1-i)*4 +: 4];
      higher_zero = higher_zero && (nib == 4'd0);
      if (idx == IDX_W'(DIGITS-1-i)) begin
        sel_digit = nib;
        sel_blank = (BLANK_LEAD_ZERO != 0) && (i != DIGITS-1) && higher_zero;
      end
    end
  end

  always_comb begin
    an_n = '1;
    if (slot == SLOT_DRIVE) begin
      for (int unsigned k = 0; k < DIGITS; k++) begin
        if (idx == IDX_W'(k)) an_n[k] = 1'b0;
      end
    end
  end

  always_comb begin
    seg_n = '1;
    if (slot == SLOT_DRIVE && !sel_blank) seg_n = seg_decode(sel_digit);
  end

endmodule

// File: doc/bcd_7seg_scanner.md
Name: bcd_7seg_scanner

Overview:
Time-multiplexed 7-segment display driver. It sits directly downstream of the binary-to-BCD converter and consumes its packed BCD output (one nibble per decimal digit). New values are accepted through a valid/ready handshake and held in a one-entry pending buffer. The visible digit register changes only at frame boundaries, so the display never tears. Each digit slot is driven with a one-cycle blanking guard to suppress ghosting.

Parameters:
DIGITS, 2, number of display digits; packed_bcd width is 4*DIGITS.
REFRESH_DIV, 1000, clock cycles per digit slot; must be >= 2.
BLANK_LEAD_ZERO, 1, 1 = suppress leading zeros on digits above digit 0.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
bcd_valid  input  1  packed_bcd holds a new value.
bcd_ready  output  1  block can accept a value (pending buffer empty).
packed_bcd  input  4*DIGITS  BCD digits; [3:0] is digit 0, the least significant digit.
seg_n  output  7  segments {g,f,e,d,c,b,a}, active low.
an_n  output  DIGITS  digit anodes, one-hot, active low; an_n[k] selects digit k.
frame_done  output  1  high during the last cycle of each frame.

Behaviour:
- Registers: cnt (0..REFRESH_DIV-1), idx (0..DIGITS-1), disp_reg, pend_reg, pend_flag.
- Outputs are a Moore decode of the registers, with no extra output pipeline stage.
- Reset: clears all registers.
  - An edge with rst high drops any pending value.
  - Resulting outputs: an_n all 1s, seg_n 7'h7F, bcd_ready 1, frame_done 0, disp_reg 0.
- Cycle 0 is the first cycle with rst low; it is the BLANK slot of digit 0.
- Scan FSM, evaluated per cycle from cnt:
  - BLANK (cnt==0): an_n all 1s, seg_n 7'h7F.
  - DRIVE (cnt 1..REFRESH_DIV-1): an_n[idx]=0, all other anode bits 1; seg_n = decode of digit idx of disp_reg.
  - cnt increments every cycle. At REFRESH_DIV-1 it wraps to 0 and idx advances; idx wraps DIGITS-1 -> 0.
  - One frame = DIGITS*REFRESH_DIV cycles.
- frame_done = (cnt==REFRESH_DIV-1) && (idx==DIGITS-1). It is high for exactly one cycle per frame.
- Handshake:
  - bcd_ready = !pend_flag.
  - On an edge with bcd_valid && bcd_ready: pend_reg <= packed_bcd, pend_flag <= 1.
  - bcd_valid while ready is low is ignored; the source must hold its data.
- Commit: on the edge ending a frame_done cycle, if pend_flag was already set before that edge, disp_reg <= pend_reg and pend_flag <= 0.
  - bcd_ready returns high the next cycle.
  - A capture on that same edge, with pend_flag previously 0, is not committed; it waits one further frame.
  - Update latency from acceptance to display is therefore 1 to 2 frames. There is no bypass path.
- Decode, seg_n hex values:
  - Digits 0-9: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Nibble > 9: dash, 7'h3F.
  - Blanked digit: 7'h7F, with its anode still driven.
- Leading-zero blanking (BLANK_LEAD_ZERO=1): digit k>0 is blanked when it and every higher digit are 0. Digit 0 is never blanked.
  - A non-zero invalid nibble (>9) counts as non-zero.
- rst asserted mid-frame or mid-handshake restarts the scan at digit 0 BLANK on the next cycle. No partial state survives.

Test Plan:
1. DIGITS=2, REFRESH_DIV=4, no input after reset -> required response:
   - cycle 0: an_n 11; cycles 1-3: an_n 10, seg_n 40.
   - cycle 4: an_n 11; cycles 5-7: an_n 01, seg_n 7F.
   - frame_done high in cycle 7 only; pattern repeats every 8 cycles.
2. bcd_valid=1 with packed_bcd 8'h42 in cycle 2 only -> required response:
   - bcd_ready low in cycles 3-7, high from cycle 8.
   - Cycles 9-11: seg_n 24. Cycles 13-15: seg_n 19.
3. bcd_valid held high from cycle 2, data 8'h15 then switched to 8'h37 at cycle 3 -> required response:
   - 8'h15 is captured at cycle 2 and displayed in frame 2: cycles 9-11 seg_n 12, cycles 13-15 seg_n 79.
   - 8'h37 is captured at cycle 8 and displayed from cycle 16: seg_n 78 on digit 0, seg_n 30 on digit 1.
4. Load 8'hA0 -> required response: digit 1 shows seg_n 3F; digit 0 shows seg_n 40 and is not blanked.
5. Load 8'h05 -> required response: digit 1 seg_n 7F, digit 0 seg_n 12. Then load 8'h50 -> required response: digit 0 seg_n 40, digit 1 seg_n 12.
6. Accept 8'h42 at cycle 2, then rst high in cycle 5 -> required response:
   - Next cycle: an_n 11, bcd_ready 1, frame_done 0.
   - Following frame shows digit 0 seg_n 40 and digit 1 seg_n 7F; 8'h42 is never displayed.
